// File: rtl/counter_seq_ctrl.sv
// Round-robin arbiter and run sequencer driving a loadable counter's load/enable/data.
// Grant is combinational in IDLE; one run in flight at a time, so ready stays low while busy.
module counter_seq_ctrl #(
  parameter int CNT_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [1:0]         req_valid_i,
  input  logic [2*CNT_W-1:0] req_start_i,
  input  logic [2*CNT_W-1:0] req_target_i,
  output logic [1:0]         req_ready_o,
  input  logic               pause_i,
  input  logic               abort_i,
  output logic               load_o,
  output logic               enable_o,
  output logic [CNT_W-1:0]   data_o,
  input  logic [CNT_W-1:0]   count_i,
  output logic               busy_o,
  output logic               grant_id_o,
  output logic               done_o,
  output logic               done_id_o,
  output logic               aborted_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   start_q, start_d;
  logic [CNT_W-1:0]   target_q, target_d;
  logic               grant_q, grant_d;
  logic               rr_q, rr_d;
  logic               done_q, done_d;
  logic               done_id_q, done_id_d;
  logic               aborted_q, aborted_d;
  logic               win;

  // rr_q names the requester that wins a tie; it flips only on an accepted request.
  always_comb begin
    case (req_valid_i)
      2'b10:   win = 1'b1;
      2'b11:   win = rr_q;
      default: win = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    target_d    = target_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    done_d      = 1'b0;
    done_id_d   = done_id_q;
    aborted_d   = 1'b0;
    req_ready_o = 2'b00;
    load_o      = 1'b0;
    enable_o    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|req_valid_i) begin
          req_ready_o[win] = 1'b1;
          start_d  = win ? req_start_i[2*CNT_W-1:CNT_W]  : req_start_i[CNT_W-1:0];
          target_d = win ? req_target_i[2*CNT_W-1:CNT_W] : req_target_i[CNT_W-1:0];
          grant_d  = win;
          rr_d     = ~win;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort_i) begin
          aborted_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          load_o  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Abort outranks a target match landing in the same cycle.
        if (abort_i) begin
          aborted_d = 1'b1;
          state_d   = S_IDLE;
        end else if (count_i == target_q) begin
          done_d    = 1'b1;
          done_id_d = grant_q;
          state_d   = S_DONE;
        end else begin
          enable_o = ~pause_i;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      start_q   <= '0;
      target_q  <= '0;
      grant_q   <= 1'b0;
      rr_q      <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      target_q  <= target_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      aborted_q <= aborted_d;
    end
  end

  assign data_o     = start_q;
  assign busy_o     = (state_q != S_IDLE);
  assign grant_id_o = grant_q;
  assign done_o     = done_q;
  assign done_id_o  = done_id_q;
  assign aborted_o  = aborted_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl: behavioural counter, table of runs, scoreboard of expected completions.
module tb_counter_seq_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [1:0] req_valid_i;
  logic [7:0] req_start_i, req_target_i;
  logic [1:0] req_ready_o;
  logic       pause_i, abort_i;
  logic       load_o, enable_o;
  logic [3:0] data_o, count_i;
  logic       busy_o, grant_id_o, done_o, done_id_o, aborted_o;

  counter_seq_ctrl #(.CNT_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_start_i(req_start_i), .req_target_i(req_target_i),
    .req_ready_o(req_ready_o), .pause_i(pause_i), .abort_i(abort_i),
    .load_o(load_o), .enable_o(enable_o), .data_o(data_o), .count_i(count_i),
    .busy_o(busy_o), .grant_id_o(grant_id_o), .done_o(done_o),
    .done_id_o(done_id_o), .aborted_o(aborted_o)
  );

  always #5 clk_i = ~clk_i;

  // Counter being sequenced: load beats enable, wraps 15->0.
  logic [3:0] cnt_q = 4'd0;
  always @(posedge clk_i) begin
    if (rst_i)         cnt_q <= 4'd0;
    else if (load_o)   cnt_q <= data_o;
    else if (enable_o) cnt_q <= cnt_q + 4'd1;
  end
  assign count_i = cnt_q;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  typedef struct {
    bit id;
    int cyc;
    int k;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit       id;
    logic [3:0] st;
    logic [3:0] tg;
    int       k;
  } vec_t;
  vec_t tbl[5];

  int abort_exp = -1;
  int en_cnt = 0;

  // Completion monitor: pops scoreboard on each done pulse.
  always @(negedge clk_i) begin
    if (load_o)        en_cnt = 0;
    else if (enable_o) en_cnt++;
    if (busy_o) chk("ready_while_busy", req_ready_o, 0);
    if (done_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_id", done_id_o, e.id);
        chk("done_cycle", cyc, e.cyc);
        chk("enable_count", en_cnt, e.k);
      end
    end
    if (aborted_o) chk("aborted_cycle", cyc, abort_exp);
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 100) begin step(); n++; end
    if (busy_o) chk("idle_timeout", 1, 0);
  endtask

  task automatic wait_sb(input int a, input int p_at, input int p_len);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      pause_i = ((cyc - a) >= p_at) && ((cyc - a) < p_at + p_len);
      step();
      n++;
    end
    pause_i = 1'b0;
    if (sb.size() != 0) begin
      chk("done_timeout", 1, 0);
      sb.delete();
    end
  endtask

  task automatic set_req(input bit id, input logic [3:0] st, input logic [3:0] tg);
    req_start_i[int'(id)*4 +: 4]  = st;
    req_target_i[int'(id)*4 +: 4] = tg;
  endtask

  task automatic do_run(input bit id, input logic [3:0] st, input logic [3:0] tg,
                        input int k, input int extra, input int p_at, input int p_len);
    int a;
    wait_idle();
    set_req(id, st, tg);
    req_valid_i = id ? 2'b10 : 2'b01;
    #1;
    chk("run_ready", req_ready_o, id ? 2 : 1);
    a = cyc;
    sb.push_back('{id: id, cyc: a + 3 + k + extra, k: k});
    step();
    req_valid_i = 2'b00;
    chk("load_pulse", load_o, 1);
    chk("load_data", data_o, st);
    chk("grant_id", grant_id_o, id);
    wait_sb(a, p_at, p_len);
  endtask

  initial begin
    int a, n, grants;
    bit exp_id;

    tbl[0] = '{id: 1'b0, st: 4'd3,  tg: 4'd7,  k: 4};
    tbl[1] = '{id: 1'b1, st: 4'd14, tg: 4'd1,  k: 3};
    tbl[2] = '{id: 1'b0, st: 4'd5,  tg: 4'd5,  k: 0};
    tbl[3] = '{id: 1'b1, st: 4'd0,  tg: 4'd15, k: 15};
    tbl[4] = '{id: 1'b0, st: 4'd9,  tg: 4'd8,  k: 15};

    rst_i = 1'b1; req_valid_i = 2'b00; req_start_i = '0; req_target_i = '0;
    pause_i = 1'b0; abort_i = 1'b0;
    repeat (3) step();
    rst_i = 1'b0;
    #1;
    chk("rst_load", load_o, 0);
    chk("rst_enable", enable_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_grant", grant_id_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_done_id", done_id_o, 0);
    chk("rst_aborted", aborted_o, 0);
    chk("rst_ready", req_ready_o, 0);

    // Both requesters held valid from reset: grants must alternate 0,1,0,1.
    set_req(1'b0, 4'd1, 4'd2);
    set_req(1'b1, 4'd2, 4'd2);
    req_valid_i = 2'b11;
    #1;
    exp_id = 1'b0; grants = 0; n = 0;
    while (grants < 4 && n < 300) begin
      if (req_ready_o != 2'b00) begin
        chk("rr_grant", req_ready_o, exp_id ? 2 : 1);
        sb.push_back('{id: exp_id, cyc: cyc + 3 + (exp_id ? 0 : 1), k: (exp_id ? 0 : 1)});
        exp_id = ~exp_id;
        grants++;
      end
      step();
      n++;
    end
    chk("rr_grant_count", grants, 4);
    req_valid_i = 2'b00;
    wait_sb(cyc, 0, 0);

    for (int i = 0; i < 5; i++)
      do_run(tbl[i].id, tbl[i].st, tbl[i].tg, tbl[i].k, 0, 0, 0);

    // Three paused RUN cycles delay completion by three.
    do_run(1'b0, 4'd0, 4'd4, 4, 3, 3, 3);
    // Pause across LOAD, the matching RUN cycle and DONE changes nothing.
    do_run(1'b0, 4'd7, 4'd7, 0, 0, 1, 3);

    // Abort in RUN, then the other requester wins a tie.
    wait_idle();
    set_req(1'b1, 4'd2, 4'd10);
    req_valid_i = 2'b10;
    #1;
    chk("abort_ready", req_ready_o, 2);
    step();
    req_valid_i = 2'b00;
    repeat (3) step();
    abort_i = 1'b1;
    #1;
    chk("abort_enable", enable_o, 0);
    chk("abort_load", load_o, 0);
    abort_exp = cyc + 1;
    step();
    abort_i = 1'b0;
    chk("abort_busy", busy_o, 0);
    chk("abort_pulse", aborted_o, 1);
    step();
    chk("abort_pulse_end", aborted_o, 0);
    abort_exp = -1;
    set_req(1'b0, 4'd4, 4'd6);
    set_req(1'b1, 4'd1, 4'd3);
    req_valid_i = 2'b11;
    #1;
    chk("post_abort_tie", req_ready_o, 1);
    sb.push_back('{id: 1'b0, cyc: cyc + 5, k: 2});
    a = cyc;
    step();
    req_valid_i = 2'b00;
    wait_sb(a, 0, 0);

    // Reset in the middle of a run, pointer left favouring requester 1.
    wait_idle();
    set_req(1'b0, 4'd3, 4'd12);
    req_valid_i = 2'b01;
    #1;
    chk("rst_run_ready", req_ready_o, 1);
    step();
    req_valid_i = 2'b00;
    repeat (3) step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("mid_rst_load", load_o, 0);
    chk("mid_rst_enable", enable_o, 0);
    chk("mid_rst_data", data_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_grant", grant_id_o, 0);
    chk("mid_rst_done", done_o, 0);
    chk("mid_rst_aborted", aborted_o, 0);
    set_req(1'b1, 4'd6, 4'd7);
    req_valid_i = 2'b11;
    #1;
    chk("mid_rst_tie", req_ready_o, 1);
    sb.push_back('{id: 1'b0, cyc: cyc + 3 + 9, k: 9});
    a = cyc;
    step();
    req_valid_i = 2'b00;
    wait_sb(a, 0, 0);
    step();

    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/counter_seq_ctrl.md
# counter_seq_ctrl

Sequencer and two-requester arbiter for the 4-bit loadable counter. Two clients each request a count run (start value, target value). The block grants one client at a time in round-robin order and drives the counter's load, enable and data inputs. It watches the count output and signals completion to the granted client. It sits between the client logic and the counter instance, and is the only driver of the counter's control inputs.

## Interface
- CNT_W, 4, counter width; start, target and count are all CNT_W bits
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- req_valid_i  in  2  per-requester run request; bit n = requester n
- req_start_i  in  2*CNT_W  start values; [CNT_W-1:0] = requester 0, upper field = requester 1
- req_target_i  in  2*CNT_W  target values, same packing as req_start_i
- req_ready_o  out  2  accept strobe; a handshake completes when valid and ready are both high
- pause_i  in  1  freezes counting while high in RUN
- abort_i  in  1  cancels the active run
- load_o  out  1  to counter load
- enable_o  out  1  to counter enable
- data_o  out  CNT_W  to counter parallel data
- count_i  in  CNT_W  from counter count output
- busy_o  out  1  high in LOAD, RUN and DONE
- grant_id_o  out  1  id of the current or last granted requester
- done_o  out  1  one-cycle completion pulse
- done_id_o  out  1  requester id qualified by done_o
- aborted_o  out  1  one-cycle abort pulse

## Operation
- Counter contract:
  - load has priority over enable.
  - The counter increments when enabled and wraps 15->0.
  - count_i reflects the new value one cycle after load or enable.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - Outputs: load_o=0, enable_o=0, busy_o=0.
  - If any req_valid_i bit is set, the arbiter picks a winner g.
  - req_ready_o[g]=1 combinationally in the same cycle; no other ready bit is set.
  - The winner's start and target are captured into internal registers; grant_id_o<=g; next state LOAD.
- Arbitration:
  - With a single requester valid, that requester wins.
  - With both valid, the winner is the requester not granted last (round-robin pointer).
  - The pointer updates only on a completed handshake.
  - After reset the pointer favours requester 0.
- LOAD: load_o=1, data_o=captured start; next state RUN.
- RUN:
  - If count_i == captured target: enable_o=0, next state DONE.
  - Otherwise enable_o = !pause_i and the state stays RUN.
  - data_o holds the captured start throughout.
- DONE: done_o=1, done_id_o=grant_id_o; next state IDLE.
- Increment count per run = (target - start) mod 2^CNT_W, ranging 0..15.
  - target < start wraps through 15->0.
  - start == target gives zero increments.
- abort_i in LOAD or RUN:
  - Next state IDLE; enable_o=0 and load_o=0 that cycle.
  - aborted_o pulses the following cycle; no done_o is issued.
  - abort_i is ignored in IDLE and DONE.
- abort_i and a count_i==target match in the same RUN cycle: abort wins.
- pause_i is ignored outside RUN. Pausing on the target-match cycle has no effect; DONE is still entered.
- Requests are never accepted while busy_o=1; ready stays 0.

## Timing
- Reset values:
  - State = IDLE; load_o=0, enable_o=0, data_o=0.
  - busy_o=0, grant_id_o=0, done_o=0, done_id_o=0, aborted_o=0.
  - Round-robin pointer favours requester 0; captured registers = 0.
- Reset mid-run: the next cycle is IDLE with all outputs at reset values. No done_o or aborted_o is issued.
- Run sequence, with the handshake in cycle A and k increments, no pause:
  - LOAD in cycle A+1.
  - RUN from A+2, where count_i == start.
  - Target match in cycle A+2+k.
  - done_o in cycle A+3+k.
  - IDLE in A+4+k, the earliest next accept.
- Each cycle with pause_i=1 in a non-matching RUN cycle adds one cycle of latency.
- load_o, enable_o and req_ready_o are combinational from state and inputs.
- done_o and aborted_o are registered.

## Test plan
- Single run: requester 0 with start=3, target=7 -> ready[0] in cycle A, load_o in A+1, four enable_o cycles, done_o with done_id_o=0 in A+7.
- Wrap: requester 1 with start=14, target=1 -> three increments (14->15->0->1), done_o at A+6, done_id_o=1.
- Zero-length: start=target=5 -> no enable_o cycles, done_o at A+3.
- Round-robin: both requesters held valid continuously from reset -> grants alternate 0,1,0,1; each ready is a one-cycle pulse, and no second grant occurs while busy_o=1.
- Pause/abort: pause_i high for 3 cycles mid-run with start=0, target=4 -> done_o delayed by 3 cycles. A separate run with abort_i in RUN -> aborted_o the next cycle, no done_o, IDLE, and the other requester can be granted.
- Reset mid-RUN: rst_i asserted for one cycle -> all outputs at reset values the following cycle, and requester 0 is favoured in the next tie.
